regfile_we_sync: RTL and testbench

- Consumer of the monostable's active-low write strobe; the clocked write side of the 74HCT670-style 4x8 register file.
- Double-synchronises the asynchronous `_we` pulse into the `clk` domain and measures its low width in clock cycles.
- Commits the held address/data on the strobe's rising edge only if the pulse met the minimum width.
- Flags too-short pulses, so the bench can prove the upstream pulse generator meets the 20ns write-pulse minimum.

---
 rtl/regfile_we_sync.sv | 161 ++++++++++++++++
 tb/tb_regfile_we_sync.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_we_sync.sv
// regfile_we_sync
// Clocked write side of a 74HCT670-style register file. The asynchronous
// active-low write strobe is double-synchronised into the clk domain and its
// low width is measured in clock cycles. The held address/data is committed on
// the strobe's rising edge only when the pulse was at least MIN_LOW_CYCLES
// long; shorter pulses are rejected and flagged.
//
// Ports:
//   clk          system clock, rising-edge active
//   _reset       asynchronous active-low reset
//   _we          asynchronous active-low write strobe
//   wr_addr      write address (stable from strobe fall through commit-1)
//   wr_data      write data (same stability rule)
//   rd_addr      read address
//   rd_data      mem[rd_addr], combinational, no write bypass
//   wr_done      one-cycle pulse per committed write
//   short_pulse  one-cycle pulse per rejected (too-short) write
//   short_err    sticky flag of any rejected write, cleared by reset only
//   write_count  committed-write counter, wraps 255 -> 0
module regfile_we_sync #(
  parameter int WIDTH          = 8,
  parameter int ADDR_BITS      = 2,
  parameter int MIN_LOW_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 _reset,
  input  logic                 _we,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 wr_done,
  output logic                 short_pulse,
  output logic                 short_err,
  output logic [7:0]           write_count
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [7:0] MIN_LOW = 8'(MIN_LOW_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    LOW  = 1'b1
  } state_t;

  state_t                 state, state_next;
  logic                   s1, s2;
  logic [7:0]             low_count, low_count_next;
  logic [ADDR_BITS-1:0]   hold_addr, hold_addr_next;
  logic [WIDTH-1:0]       hold_data, hold_data_next;
  logic                   commit, reject;
  logic [WIDTH-1:0]       mem [DEPTH];

  // Two-flop synchroniser; idle level of the strobe is high.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= _we;
      s2 <= s1;
    end
  end

  // Next-state, width measurement and commit/reject decision.
  always_comb begin
    state_next     = state;
    low_count_next = low_count;
    hold_addr_next = hold_addr;
    hold_data_next = hold_data;
    commit         = 1'b0;
    reject         = 1'b0;
    case (state)
      IDLE: begin
        if (!s2) begin
          state_next     = LOW;
          low_count_next = 8'd1;
          hold_addr_next = wr_addr;
          hold_data_next = wr_data;
        end else begin
          state_next = IDLE;
        end
      end
      LOW: begin
        if (!s2) begin
          // Saturate so a very long pulse still counts as valid.
          if (low_count != 8'hFF) begin
            low_count_next = low_count + 8'd1;
          end else begin
            low_count_next = low_count;
          end
          // Last capture before the rising edge wins.
          hold_addr_next = wr_addr;
          hold_data_next = wr_data;
        end else begin
          if (low_count >= MIN_LOW) begin
            commit = 1'b1;
          end else begin
            reject = 1'b1;
          end
          state_next     = IDLE;
          low_count_next = 8'd0;
        end
      end
      default: begin
        state_next     = IDLE;
        low_count_next = 8'd0;
      end
    endcase
  end

  // FSM state, width counter and held write operands.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state     <= IDLE;
      low_count <= 8'd0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      state     <= state_next;
      low_count <= low_count_next;
      hold_addr <= hold_addr_next;
      hold_data <= hold_data_next;
    end
  end

  // Registered status pulses, sticky error and commit counter.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      wr_done     <= 1'b0;
      short_pulse <= 1'b0;
      short_err   <= 1'b0;
      write_count <= 8'd0;
    end else begin
      wr_done     <= commit;
      short_pulse <= reject;
      if (reject) begin
        short_err <= 1'b1;
      end
      if (commit) begin
        write_count <= write_count + 8'd1;
      end
    end
  end

  // Register file storage; written only on a committed pulse.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (commit) begin
        mem[hold_addr] <= hold_data;
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: tb/tb_regfile_we_sync.sv
// tb_regfile_we_sync
// Self-checking bench for regfile_we_sync. A pulse of L low cycles is driven
// on _we; the reference model says the write lands iff L >= MIN, exactly two
// edges after the rise is first sampled, and tracks memory, counter and the
// sticky error flag with plain arrays and integers.
module tb_regfile_we_sync;

  localparam int MIN = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       we_n = 1'b1;
  logic [1:0] wr_addr = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic [1:0] rd_addr = 2'd0;
  logic [7:0] rd_data;
  logic       wr_done, short_pulse, short_err;
  logic [7:0] write_count;

  logic [7:0] mdl_mem [4];
  int         mdl_count;
  bit         mdl_err;

  int errors = 0;
  int checks = 0;

  bit mon_en = 1'b0;
  int done_seen = 0;
  int both_seen = 0;

  regfile_we_sync #(.WIDTH(8), .ADDR_BITS(2), .MIN_LOW_CYCLES(MIN)) dut (
    .clk(clk), ._reset(reset_n), ._we(we_n),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_done(wr_done), .short_pulse(short_pulse),
    .short_err(short_err), .write_count(write_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      if (wr_done) done_seen++;
      if (wr_done && short_pulse) both_seen++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mdl_mem[i] = 8'h00;
    mdl_count = 0;
    mdl_err = 1'b0;
  endtask

  task automatic check_all_words(input string tag);
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      check_eq(tag, 32'(rd_data), 32'(mdl_mem[i]));
    end
  endtask

  // _we already low at a negedge with operands applied; hold for len edges,
  // release, and check the outcome two edges after the rise is sampled.
  task automatic finish_pulse(input int len, input logic [1:0] a, input logic [7:0] d);
    bit ok;
    ok = (len >= MIN);
    rd_addr = a;
    repeat (len) @(negedge clk);
    we_n = 1'b1;
    @(negedge clk);
    check_eq("early_done", 32'(wr_done), 32'd0);
    @(negedge clk);
    check_eq("early_short", 32'(short_pulse), 32'd0);
    check_eq("no_bypass", 32'(rd_data), 32'(mdl_mem[a]));
    @(negedge clk);
    if (ok) begin
      mdl_mem[a] = d;
      mdl_count = (mdl_count + 1) % 256;
    end else begin
      mdl_err = 1'b1;
    end
    check_eq("wr_done", 32'(wr_done), 32'(ok));
    check_eq("short_pulse", 32'(short_pulse), 32'(!ok));
    check_eq("write_count", 32'(write_count), 32'(mdl_count));
    check_eq("short_err", 32'(short_err), 32'(mdl_err));
    check_eq("rd_after", 32'(rd_data), 32'(mdl_mem[a]));
  endtask

  task automatic pulse(input int len, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    we_n = 1'b0;
    wr_addr = a;
    wr_data = d;
    finish_pulse(len, a, d);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_all_words("reset_mem");
    check_eq("reset_done", 32'(wr_done), 32'd0);
    check_eq("reset_err", 32'(short_err), 32'd0);
    check_eq("reset_count", 32'(write_count), 32'd0);

    // Directed: valid write, then a too-short one
    pulse(3, 2'd2, 8'hA5);
    check_all_words("after_a5");
    pulse(1, 2'd1, 8'h3C);
    @(negedge clk);
    check_eq("short_one_cycle", 32'(short_pulse), 32'd0);
    check_eq("short_sticky", 32'(short_err), 32'd1);
    check_all_words("after_short");

    // Back-to-back pulses with one high cycle between
    done_seen = 0;
    both_seen = 0;
    mon_en = 1'b1;
    @(negedge clk);
    we_n = 1'b0;
    wr_addr = 2'd0;
    wr_data = 8'h11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_addr = 2'(i);
      wr_data = 8'(8'h11 * (i + 1));
      repeat (2) @(negedge clk);
      we_n = 1'b1;
      @(negedge clk);
      if (i < 3) we_n = 1'b0;
      mdl_mem[i] = 8'(8'h11 * (i + 1));
      mdl_count = (mdl_count + 1) % 256;
    end
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    check_eq("b2b_dones", 32'(done_seen), 32'd4);
    check_eq("b2b_both", 32'(both_seen), 32'd0);
    check_eq("b2b_count", 32'(write_count), 32'(mdl_count));
    check_all_words("b2b_mem");

    // Data changes mid-pulse; last stable value wins
    @(negedge clk);
    we_n = 1'b0;
    wr_addr = 2'd3;
    wr_data = 8'h10;
    @(negedge clk);
    wr_data = 8'h20;
    finish_pulse(3, 2'd3, 8'h20);

    // Reset mid-pulse, release with _we low 5 more cycles
    @(negedge clk);
    we_n = 1'b0;
    wr_addr = 2'd1;
    wr_data = 8'h5A;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_mid_count", 32'(write_count), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_mid_done", 32'(wr_done), 32'd0);
    end
    reset_n = 1'b1;
    finish_pulse(5, 2'd1, 8'h5A);
    check_all_words("rst_long_mem");

    // Reset mid-pulse, release with _we low one more cycle -> short
    @(negedge clk);
    we_n = 1'b0;
    wr_addr = 2'd2;
    wr_data = 8'h77;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    finish_pulse(1, 2'd2, 8'h77);

    // Randomised pulses
    for (int i = 0; i < 40; i++) begin
      pulse(int'($urandom_range(1, 5)), 2'($urandom_range(0, 3)), 8'($urandom));
    end
    check_all_words("rand_mem");

    // 256 valid writes from reset wrap the counter to zero
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pulse(MIN + int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom));
    end
    check_eq("wrap_count", 32'(write_count), 32'd0);
    check_eq("wrap_err", 32'(short_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
